// File: rtl/card_pkg.sv
// Shared constants, state encoding and card-value helper for the blackjack card source.
package card_pkg;

    localparam int DECK_SIZE  = 52;
    localparam int RANKS      = 13;
    localparam int FACE_VALUE = 10;
    localparam int CARD_W     = 5;
    localparam int IDX_W      = 6;

    localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);

    // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting Fibonacci register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_e;

    function automatic logic [CARD_W-1:0] rank_value(input logic [IDX_W-1:0] idx,
                                                     input logic [CARD_W-1:0] ace_val);
        logic [IDX_W-1:0] rank;
        if (idx >= IDX_W'(3 * RANKS))      rank = idx - IDX_W'(3 * RANKS);
        else if (idx >= IDX_W'(2 * RANKS)) rank = idx - IDX_W'(2 * RANKS);
        else if (idx >= IDX_W'(RANKS))     rank = idx - IDX_W'(RANKS);
        else                               rank = idx;

        if (rank == '0)              return ace_val;
        else if (rank < IDX_W'(10))  return CARD_W'(rank + IDX_W'(1));
        else                         return CARD_W'(FACE_VALUE);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, reset loads SEED (must be nonzero).
module lfsr16
    import card_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clock,
    input  logic        reset_n,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) lfsr_q <= SEED;
        else          lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Draws cards without replacement from a 52-card deck and strobes the blackjack value.
// Optional build macro CARD_DEALER_AUTO_SHUFFLE_EN: a request on an empty deck reshuffles and deals.
module card_dealer
    import card_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned ACE_VALUE = 1
) (
    input  logic              Clock,
    input  logic              reset_n,
    input  logic              req,
    input  logic              shuffle,
    output logic [CARD_W-1:0] card,
    output logic              card_valid,
    output logic              busy,
    output logic [IDX_W-1:0]  cards_left,
    output logic              deck_empty
);

    localparam logic [CARD_W-1:0] ACE_V = CARD_W'(ACE_VALUE);

    state_e                 state_q, state_d;
    logic [DECK_SIZE-1:0]   dealt_q, dealt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CARD_W-1:0]      card_q, card_d;
    logic                   card_valid_q, card_valid_d;
    logic [IDX_W-1:0]       cards_left_q, cards_left_d;
    logic                   deck_empty_q, deck_empty_d;

    logic [15:0]            lfsr;
    logic [IDX_W-1:0]       draw_idx;
    logic                   unused_lfsr_bits;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .Clock  (Clock),
        .reset_n(reset_n),
        .q      (lfsr)
    );

    // Fold the 6-bit random draw into 0..51; slight bias toward low indices is acceptable.
    assign draw_idx = (lfsr[IDX_W-1:0] >= FULL_CNT) ? (lfsr[IDX_W-1:0] - FULL_CNT)
                                                    : lfsr[IDX_W-1:0];
    assign unused_lfsr_bits = ^lfsr[15:IDX_W];

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge Clock or negedge reset_n) begin
        if (!reset_n) begin
            dealt_q      <= '0;
            idx_q        <= '0;
            card_q       <= '0;
            card_valid_q <= 1'b0;
            cards_left_q <= FULL_CNT;
            deck_empty_q <= 1'b0;
        end else begin
            dealt_q      <= dealt_d;
            idx_q        <= idx_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            cards_left_q <= cards_left_d;
            deck_empty_q <= deck_empty_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dealt_d      = dealt_q;
        idx_d        = idx_q;
        card_d       = card_q;
        card_valid_d = 1'b0;
        cards_left_d = cards_left_q;
        deck_empty_d = deck_empty_q;

        case (state_q)
            IDLE: begin
                if (shuffle) begin
                    dealt_d      = '0;
                    cards_left_d = FULL_CNT;
                    deck_empty_d = 1'b0;
                end else if (req) begin
                    if (cards_left_q != '0) begin
                        idx_d   = draw_idx;
                        state_d = PROBE;
                    end
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
                    else begin
                        dealt_d      = '0;
                        cards_left_d = FULL_CNT;
                        deck_empty_d = 1'b0;
                        idx_d        = draw_idx;
                        state_d      = PROBE;
                    end
`endif
                end
            end
            PROBE: begin
                if (shuffle) begin
                    dealt_d      = '0;
                    cards_left_d = FULL_CNT;
                    deck_empty_d = 1'b0;
                    state_d      = IDLE;
                end else if (!dealt_q[idx_q]) begin
                    dealt_d[idx_q] = 1'b1;
                    card_d         = rank_value(idx_q, ACE_V);
                    card_valid_d   = 1'b1;
                    cards_left_d   = cards_left_q - IDX_W'(1);
                    deck_empty_d   = (cards_left_q == IDX_W'(1));
                    state_d        = IDLE;
                end else begin
                    // Linear probe; always terminates since at least one card remains.
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == PROBE);
        card       = card_q;
        card_valid = card_valid_q;
        cards_left = cards_left_q;
        deck_empty = deck_empty_q;
    end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: cycle table for the opening sequence, then scoreboarded draws.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'h0005;

    logic       Clock;
    logic       reset_n;
    logic       req;
    logic       shuffle;
    logic [4:0] card;
    logic       card_valid;
    logic       busy;
    logic [5:0] cards_left;
    logic       deck_empty;

    int n_cmp  = 0;
    int n_fail = 0;

    card_dealer #(
        .LFSR_SEED(SEED),
        .ACE_VALUE(1)
    ) dut (
        .Clock     (Clock),
        .reset_n   (reset_n),
        .req       (req),
        .shuffle   (shuffle),
        .card      (card),
        .card_valid(card_valid),
        .busy      (busy),
        .cards_left(cards_left),
        .deck_empty(deck_empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference LFSR written straight from the polynomial.
    logic [15:0] m_lfsr;
    always @(posedge Clock or negedge reset_n) begin
        if (!reset_n) m_lfsr <= SEED;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    logic [51:0] m_dealt;
    int          m_left;

    typedef struct {
        logic [4:0] card;
        int         left;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       req;
        logic       shuffle;
        logic       exp_busy;
        logic       exp_cv;
        logic [4:0] exp_card;
        logic [5:0] exp_left;
        logic       exp_empty;
    } vec_t;
    vec_t tbl[9];

    int hist[11];
    int sum;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int card_val(input int idx);
        int r;
        r = idx % 13;
        if (r == 0) return 1;
        if (r < 10) return r + 1;
        return 10;
    endfunction

    task automatic do_shuffle();
        shuffle = 1'b1;
        @(negedge Clock);
        shuffle = 1'b0;
        m_dealt = '0;
        m_left  = 52;
        sb.delete();
        check("shuffle_left", cards_left, 52);
        check("shuffle_busy", busy, 0);
    endtask

    // Issue one request (called at a negedge with busy low) and wait for its strobe.
    task automatic draw(input bit extra, output int got);
        int   idx, k, lat;
        int   busy_err;
        bit   seen;
        exp_t e;
        got = 0;
        if (m_left == 0) begin
`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
            m_dealt = '0;
            m_left  = 52;
`endif
        end
        idx = int'(m_lfsr[5:0]);
        if (idx >= 52) idx -= 52;
        k = 1;
        while (m_dealt[idx]) begin
            idx = (idx == 51) ? 0 : idx + 1;
            k++;
        end
        m_dealt[idx] = 1'b1;
        m_left--;
        e.card = 5'(card_val(idx));
        e.left = m_left;
        e.lat  = k + 1;
        sb.push_back(e);

        req      = 1'b1;
        seen     = 1'b0;
        lat      = 0;
        busy_err = 0;
        for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
            @(negedge Clock);
            if (card_valid) begin
                seen = 1'b1;
                lat  = cyc;
            end else if (!busy) begin
                busy_err++;
            end
            req = extra && !card_valid && (cyc <= k);
        end
        req = 1'b0;
        check("draw_busy_while_probing", busy_err, 0);
        if (!seen) begin
            check("draw_timeout", 0, 1);
            sb.delete();
        end else if (sb.size() == 0) begin
            check("draw_unexpected_strobe", 1, 0);
        end else begin
            e   = sb.pop_front();
            got = int'(card);
            check("draw_card", card, e.card);
            check("draw_left", cards_left, e.left);
            check("draw_empty", deck_empty, (e.left == 0) ? 1 : 0);
            check("draw_busy_at_strobe", busy, 0);
            check("draw_latency", lat, e.lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int errs_cv, errs_busy, errs_left, errs_empty;

        //              req sh  busy cv card left empty
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd52, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 6'd52, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 6'd51, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd6, 6'd51, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 6'd52, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 6'd52, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd6, 6'd52, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 6'd51, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 6'd51, 1'b0};

        req     = 1'b0;
        shuffle = 1'b0;
        reset_n = 1'b0;
        m_dealt = '0;
        m_left  = 52;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            check($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("vec%0d_valid", i), card_valid, tbl[i].exp_cv);
            check($sformatf("vec%0d_card", i), card, tbl[i].exp_card);
            check($sformatf("vec%0d_left", i), cards_left, tbl[i].exp_left);
            check($sformatf("vec%0d_empty", i), deck_empty, tbl[i].exp_empty);
            req     = tbl[i].req;
            shuffle = tbl[i].shuffle;
            @(negedge Clock);
        end
        req     = 1'b0;
        shuffle = 1'b0;

        // Full deck: 52 draws, extra requests during busy on every third draw.
        do_shuffle();
        for (int i = 0; i < 11; i++) hist[i] = 0;
        sum = 0;
        for (int i = 0; i < 52; i++) begin
            draw((i % 3) == 1, v);
            if (v >= 0 && v <= 10) hist[v]++;
            sum += v;
        end
        check("deck_count_10", hist[10], 16);
        for (int i = 1; i <= 9; i++) check($sformatf("deck_count_%0d", i), hist[i], 4);
        check("deck_sum", sum, 340);
        check("deck_left_zero", cards_left, 0);
        check("deck_empty_set", deck_empty, 1);

`ifdef CARD_DEALER_AUTO_SHUFFLE_EN
        draw(1'b0, v);
        check("auto_left", cards_left, 51);
        check("auto_empty", deck_empty, 0);
`else
        req = 1'b1;
        @(negedge Clock);
        req = 1'b0;
        errs_cv = 0; errs_busy = 0; errs_left = 0; errs_empty = 0;
        for (int c = 0; c < 60; c++) begin
            if (card_valid) errs_cv++;
            if (busy) errs_busy++;
            if (cards_left != 6'd0) errs_left++;
            if (!deck_empty) errs_empty++;
            @(negedge Clock);
        end
        check("empty_no_strobe", errs_cv, 0);
        check("empty_no_busy", errs_busy, 0);
        check("empty_left_stays", errs_left, 0);
        check("empty_flag_stays", errs_empty, 0);
`endif

        // Shuffle one cycle after an accepted request aborts the draw.
        do_shuffle();
        for (int i = 0; i < 10; i++) draw(1'b0, v);
        req = 1'b1;
        @(negedge Clock);
        req = 1'b0;
        check("abort_busy_c1", busy, 1);
        shuffle = 1'b1;
        @(negedge Clock);
        shuffle = 1'b0;
        m_dealt = '0;
        m_left  = 52;
        check("abort_no_strobe", card_valid, 0);
        check("abort_left", cards_left, 52);
        check("abort_busy", busy, 0);
        errs_cv = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            if (card_valid) errs_cv++;
        end
        check("abort_quiet", errs_cv, 0);

        // Reset in the middle of a probe.
        for (int i = 0; i < 3; i++) draw(1'b0, v);
        req = 1'b1;
        @(negedge Clock);
        req = 1'b0;
        check("rst_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_card", card, 0);
        check("rst_valid", card_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_left", cards_left, 52);
        check("rst_empty", deck_empty, 0);
        errs_cv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clock);
            if (card_valid || busy) errs_cv++;
        end
        check("rst_quiet", errs_cv, 0);
        reset_n = 1'b1;
        m_dealt = '0;
        m_left  = 52;
        draw(1'b1, v);
        check("post_rst_first_card", v, 6);
        for (int i = 0; i < 4; i++) draw(1'b1, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
